// File: rtl/mux4_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux4_rr_scheduler
//   Round-robin scheduler that shares one 4:1 single-bit data mux among four
//   requesters. Each grant lasts at most BURST_LEN consecutive cycles. The
//   block owns the mux select/enable and registers the selected data bit.
//
// Ports
//   clk      in   1  rising-edge clock
//   reset_n  in   1  synchronous reset, active-low
//   req      in   4  level-sensitive request, bit i = requester i
//   data     in   4  mux data inputs, bit i belongs to requester i
//   sel      out  2  mux select, index of the granted requester
//   en       out  1  mux enable, 1 while a grant is active
//   grant    out  4  one-hot grant, en ? 1<<sel : 0
//   out      out  1  registered mux output (lags sel/en by one cycle)
//   busy     out  1  1 while the FSM is in GRANT
// ---------------------------------------------------------------------------
module mux4_rr_scheduler #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] data,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] grant,
    output logic       out,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             out_nxt;
    logic [1:0]       pick;
    logic             rel_now;

    // Search order last+1, last+2, last+3, last (mod 4); the 2-bit add wraps
    // naturally, so the previous holder is only reached in the final slot.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        last_nxt  = last;
        pick      = rr_pick(req, last);
        rel_now   = (state == GRANT) && (!req[sel] || (cnt == BURST_MAX));
        out_nxt   = (state == GRANT) ? data[sel] : 1'b0;

        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    cnt_nxt   = CNT_ONE;
                    last_nxt  = pick;
                end
            end
            GRANT: begin
                if (rel_now) begin
                    // Release and re-grant on the same edge: no idle gap.
                    if (req != 4'b0000) begin
                        sel_nxt  = pick;
                        cnt_nxt  = CNT_ONE;
                        last_nxt = pick;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= '0;
            last  <= 2'd3;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            out   <= out_nxt;
        end
    end

    assign en    = (state == GRANT);
    assign busy  = en;
    assign grant = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_scheduler
//   Two instances share the stimulus: BURST_LEN=4 and BURST_LEN=1. A
//   behavioural model (holder index + cycles used) predicts every output.
// ---------------------------------------------------------------------------
module tb_mux4_rr_scheduler;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] data;

    logic [1:0] sel0, sel1;
    logic       en0, en1;
    logic [3:0] grant0, grant1;
    logic       out0, out1;
    logic       busy0, busy1;

    int total;
    int bad;

    mux4_rr_scheduler #(.BURST_LEN(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data(data),
        .sel(sel0), .en(en0), .grant(grant0), .out(out0), .busy(busy0)
    );

    mux4_rr_scheduler #(.BURST_LEN(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .data(data),
        .sel(sel1), .en(en1), .grant(grant1), .out(out1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = BURST_LEN 4, index 1 = BURST_LEN 1.
    int m_holder[2];   // -1 when nobody holds the mux
    int m_used[2];     // cycles consumed by the current burst
    int m_sel[2];
    int m_last[2];
    int m_out[2];

    function automatic int pick_of(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input int burst);
        int nout;
        int p;
        if (!reset_n) begin
            m_holder[i] = -1;
            m_used[i]   = 0;
            m_sel[i]    = 0;
            m_last[i]   = 3;
            m_out[i]    = 0;
            return;
        end
        nout = (m_holder[i] >= 0) ? int'(data[m_sel[i]]) : 0;
        p    = pick_of(m_last[i], req);
        if (m_holder[i] < 0 || !req[m_holder[i]] || m_used[i] >= burst) begin
            if (p >= 0) begin
                m_holder[i] = p;
                m_sel[i]    = p;
                m_last[i]   = p;
                m_used[i]   = 1;
            end else begin
                m_holder[i] = -1;
            end
        end else begin
            m_used[i]++;
        end
        m_out[i] = nout;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic       e0, e1;
        logic [3:0] g0, g1;
        e0 = (m_holder[0] >= 0);
        e1 = (m_holder[1] >= 0);
        g0 = e0 ? (4'b0001 << m_sel[0]) : 4'b0000;
        g1 = e1 ? (4'b0001 << m_sel[1]) : 4'b0000;
        check("b4_sel",   8'(sel0),   8'(m_sel[0]));
        check("b4_en",    8'(en0),    8'(e0));
        check("b4_grant", 8'(grant0), 8'(g0));
        check("b4_out",   8'(out0),   8'(m_out[0]));
        check("b4_busy",  8'(busy0),  8'(e0));
        check("b1_sel",   8'(sel1),   8'(m_sel[1]));
        check("b1_en",    8'(en1),    8'(e1));
        check("b1_grant", 8'(grant1), 8'(g1));
        check("b1_out",   8'(out1),   8'(m_out[1]));
        check("b1_busy",  8'(busy1),  8'(e1));
    endtask

    // Inputs are set before calling; model advances, then outputs are
    // sampled 1 time unit after the edge.
    task automatic step();
        model_step(0, 4);
        model_step(1, 1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int c = 0; c < cycles; c++) step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] prev_sel;
        logic       prev_d;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        req     = 4'hF;
        data    = 4'hF;
        for (int i = 0; i < 2; i++) begin
            m_holder[i] = -1; m_used[i] = 0; m_sel[i] = 0; m_last[i] = 3; m_out[i] = 0;
        end
        #2;

        // 1. Reset with everything asserted: all outputs zero each cycle.
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_grant_zero", 8'(grant0), 8'h00);
            check("rst_out_zero",   8'(out0),   8'h00);
        end

        // 2. Sole requester 2: grant after one edge, out one edge later,
        //    re-grant at burst expiry without an en gap.
        reset_n = 1'b1;
        req     = 4'b0100;
        data    = 4'b0100;
        step();
        check("t2_sel2",  8'(sel0),   8'd2);
        check("t2_grant", 8'(grant0), 8'b0100);
        step();
        check("t2_out1",  8'(out0),   8'd1);
        for (int c = 0; c < 8; c++) begin
            step();
            check("t2_en_nogap", 8'(en0), 8'd1);
        end

        // 3. All requesting: 4-cycle bursts rotating, en never drops.
        req = 4'hF;
        for (int c = 0; c < 20; c++) begin
            data = 4'($urandom);
            step();
            check("t3_en_held", 8'(en0), 8'd1);
        end

        // 4. Holder 0 drops req in cycle 2 of its burst.
        do_reset(1);
        req = 4'b0011;
        step();
        check("t4_first0", 8'(grant0), 8'b0001);
        step();
        req = 4'b0010;
        step();
        check("t4_switch1", 8'(grant0), 8'b0010);
        do_reset(1);
        req = 4'b0001;
        step();
        step();
        req = 4'b0000;
        step();
        check("t4_en_off", 8'(en0), 8'd0);
        step();
        check("t4_out_off", 8'(out0), 8'd0);

        // 5. Reset mid-burst while requester 2 holds; restart at 0.
        do_reset(1);
        req = 4'hF;
        for (int c = 0; c < 9; c++) step();
        check("t5_holder2", 8'(sel0), 8'd2);
        do_reset(1);
        check("t5_rst_en", 8'(en0), 8'd0);
        step();
        check("t5_restart0", 8'(grant0), 8'b0001);

        // 6. Two requesters, BURST_LEN 1 instance alternates every cycle.
        do_reset(1);
        req = 4'b1010;
        step();
        for (int c = 0; c < 10; c++) begin
            prev_sel = sel1;
            data     = 4'($urandom);
            prev_d   = data[prev_sel];
            step();
            check("t6_alt",   8'(sel1), 8'(prev_sel ^ 2'b10));
            check("t6_track", 8'(out1), 8'(prev_d));
        end

        // Randomised run: sticky requests with occasional reset.
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            data = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
